prog_ctr: RTL and testbench

- Fetch-side program counter stage directly downstream of the ALU.
- Consumes the ALU branch flags (notequal, lessthan) and decoder control, and produces the instruction-memory address for the next fetch.
- Branch targets are absolute addresses held in a small lookup table, indexed by the 4-bit immediate field of the branch instruction.
- Owns the run/halt sequencing and a retired-instruction counter used by the test harness.

---
 rtl/prog_ctr_pkg.sv | 11 +
 rtl/prog_ctr_branch_lut.sv | 9 +
 rtl/prog_ctr.sv | 57 +++++
 tb/tb_prog_ctr.sv | 125 ++++++++++++
 4 files changed

// File: rtl/prog_ctr_pkg.sv
// prog_ctr_pkg: FSM state type, default PC width and the fixed 16-entry branch target table
package prog_ctr_pkg;
  localparam int DEF_PC_W = 10;
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  localparam logic [DEF_PC_W-1:0] BR_LUT [16] = '{
    10'h000, 10'h010, 10'h040, 10'h3F0,
    10'h000, 10'h000, 10'h000, 10'h000,
    10'h000, 10'h000, 10'h000, 10'h000,
    10'h000, 10'h000, 10'h000, 10'h000
  };
endpackage

// File: rtl/prog_ctr_branch_lut.sv
// branch_lut: combinational ROM, br_idx[3:0] in -> absolute branch target out
module branch_lut
  import prog_ctr_pkg::*;
(
  input  logic [3:0]          br_idx,
  output logic [DEF_PC_W-1:0] target
);
  assign target = BR_LUT[br_idx];
endmodule

// File: rtl/prog_ctr.sv
// prog_ctr: fetch PC with IDLE/RUN/HALT sequencing, LUT branches and saturating retired count (clk, rst_n, start, stall, halt_req, br_*, flags, br_idx -> pc, busy, done, branch_taken, retired)
module prog_ctr
  import prog_ctr_pkg::*;
#(
  parameter int              PC_W       = DEF_PC_W,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter int              CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             br_ne_en,
  input  logic             br_lt_en,
  input  logic             notequal,
  input  logic             lessthan,
  input  logic [3:0]       br_idx,
  output logic [PC_W-1:0]  pc,
  output logic             busy,
  output logic             done,
  output logic             branch_taken,
  output logic [CNT_W-1:0] retired
);
  state_t state, nxt;
  logic [DEF_PC_W-1:0] target;
  logic taken, adv, go;
  branch_lut u_lut (.br_idx(br_idx), .target(target));
  assign taken = (br_ne_en & notequal) | (br_lt_en & lessthan);
  assign adv   = state == RUN && !stall;
  assign go    = start && state != RUN;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state == RUN ? (adv && halt_req ? HALT : RUN) : (start ? RUN : state);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc           <= START_ADDR;
      retired      <= '0;
      branch_taken <= 1'b0;
    end else begin
      branch_taken <= adv && !halt_req && taken;
      if (go) begin
        pc      <= START_ADDR;
        retired <= '0;
      end else if (adv) begin
        retired <= &retired ? retired : retired + CNT_W'(1);
        pc      <= halt_req ? pc : taken ? PC_W'(target) : pc + PC_W'(1);
      end
    end
  always_comb begin
    busy = state == RUN;
    done = state == HALT;
  end
endmodule

// File: tb/tb_prog_ctr.sv
// tb_prog_ctr: scoreboard bench for prog_ctr (full-width and CNT_W=4 builds) against a behavioural model
module tb_prog_ctr;
  typedef struct {
    int pc;
    bit busy;
    bit done;
    bit bt;
    int ret;
  } exp_t;
  logic       clk = 0, rst_n = 0;
  logic       start = 0, stall = 0, halt_req = 0, br_ne_en = 0, br_lt_en = 0, notequal = 0, lessthan = 0;
  logic [3:0] br_idx = 0;
  logic [9:0] pc, pc4;
  logic       busy, done, bt, busy4, done4, bt4;
  logic [15:0] retired;
  logic [3:0]  retired4;
  int n_cmp = 0, n_err = 0;
  exp_t q[$];
  int lut[16] = '{'h000, 'h010, 'h040, 'h3F0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  bit m_run = 0, m_halt = 0;
  int m_pc = 0, m_cnt = 0;
  prog_ctr u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt_req(halt_req),
    .br_ne_en(br_ne_en), .br_lt_en(br_lt_en), .notequal(notequal), .lessthan(lessthan),
    .br_idx(br_idx), .pc(pc), .busy(busy), .done(done), .branch_taken(bt), .retired(retired)
  );
  prog_ctr #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt_req(halt_req),
    .br_ne_en(br_ne_en), .br_lt_en(br_lt_en), .notequal(notequal), .lessthan(lessthan),
    .br_idx(br_idx), .pc(pc4), .busy(busy4), .done(done4), .branch_taken(bt4), .retired(retired4)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  task automatic chk_all(input exp_t e);
    chk("pc", 32'(pc), e.pc);
    chk("busy", 32'(busy), 32'(e.busy));
    chk("done", 32'(done), 32'(e.done));
    chk("branch_taken", 32'(bt), 32'(e.bt));
    chk("retired", 32'(retired), e.ret > 65535 ? 65535 : e.ret);
    chk("pc_w4", 32'(pc4), e.pc);
    chk("busy_w4", 32'(busy4), 32'(e.busy));
    chk("done_w4", 32'(done4), 32'(e.done));
    chk("branch_taken_w4", 32'(bt4), 32'(e.bt));
    chk("retired_sat4", 32'(retired4), e.ret > 15 ? 15 : e.ret);
  endtask
  task automatic rst_chk();
    exp_t e;
    e.pc = 0; e.busy = 0; e.done = 0; e.bt = 0; e.ret = 0;
    chk_all(e);
  endtask
  task automatic model_step();
    exp_t e;
    e.bt = 0;
    if (!m_run) begin
      if (start) begin
        m_run = 1; m_halt = 0; m_pc = 0; m_cnt = 0;
      end
    end else if (!stall) begin
      m_cnt++;
      if (halt_req) begin
        m_run = 0; m_halt = 1;
      end else if ((br_ne_en && notequal) || (br_lt_en && lessthan)) begin
        m_pc = lut[br_idx]; e.bt = 1;
      end else m_pc = (m_pc + 1) % 1024;
    end
    e.pc = m_pc; e.busy = m_run; e.done = m_halt; e.ret = m_cnt;
    q.push_back(e);
  endtask
  task automatic cyc(input bit s, input bit sl, input bit h, input bit ne, input bit lt,
                     input bit nq, input bit ls, input int idx);
    start = s; stall = sl; halt_req = h; br_ne_en = ne; br_lt_en = lt;
    notequal = nq; lessthan = ls; br_idx = idx[3:0];
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic plain(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)));
  endtask
  task automatic rand_run(input int n);
    repeat (n) cyc($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)));
  endtask
  initial forever begin
    @(negedge clk);
    if (q.size() > 0) chk_all(q.pop_front());
  end
  initial begin
    #12 rst_chk();
    @(negedge clk) rst_n = 1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    plain(5);
    cyc(0, 0, 0, 1, 0, 1, 0, 2);
    cyc(0, 0, 0, 0, 1, 1, 0, 3);
    cyc(0, 1, 1, 0, 1, 0, 1, 1);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    plain(2);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 1, 0, 3);
    plain(20);
    cyc(0, 0, 0, 1, 1, 1, 1, 1);
    rand_run(400);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    plain(3);
    @(negedge clk);
    #1 rst_n = 0;
    #1 rst_chk();
    m_run = 0; m_halt = 0; m_pc = 0; m_cnt = 0;
    @(posedge clk);
    #1 rst_chk();
    @(negedge clk) rst_n = 1;
    rand_run(300);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
